bp_fe_bht_idx_gen: RTL and testbench

- Front-end stage directly upstream of the tournament/BHT predictor.
- Hashes the fetch PC with a speculative global history register (GHR) to form `idx_r_o` and `r_v_o`, and forwards the predictor's `predict_i` to fetch.
- Tracks in-flight predictions in an in-order FIFO. On backend resolution it drives the predictor's update port (`w_v_o`, `idx_w_o`, `correct_o`) and repairs the GHR on mispredict.

---
 rtl/bp_fe_bp_pkg.sv | 33 +++
 rtl/bp_fe_bp_inflight_fifo.sv | 72 +++++++
 rtl/bp_fe_bht_idx_gen.sv | 180 ++++++++++++++++++
 tb/tb_bp_fe_bht_idx_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_bp_pkg.sv
// Shared types for the BHT index generator and its in-flight prediction FIFO.
// The macro BP_FE_IDX_GEN_GSHARE_EN selects gshare (GHR snapshot stored per
// entry) versus bimodal (no history) entry layout.
package bp_fe_bp_pkg;

   localparam int BP_BHT_IDX_W_DEF = 9;
   localparam int BP_GHIST_W_DEF   = 9;

`ifdef BP_FE_IDX_GEN_GSHARE_EN
   localparam bit BP_GSHARE_EN = 1'b1;

   // Canonical in-flight entry layout at the default widths.
   typedef struct packed {
      logic [BP_BHT_IDX_W_DEF-1:0] idx;
      logic                        pred;
      logic [BP_GHIST_W_DEF-1:0]   ghist;
   } bp_inflight_entry_s;
`else
   localparam bit BP_GSHARE_EN = 1'b0;

   typedef struct packed {
      logic [BP_BHT_IDX_W_DEF-1:0] idx;
      logic                        pred;
   } bp_inflight_entry_s;
`endif

   // Entry width for arbitrary index/history widths; the ghist field only
   // exists when gshare is built in.
   function automatic int bp_entry_width(input int idx_w, input int ghist_w);
      return BP_GSHARE_EN ? (idx_w + 1 + ghist_w) : (idx_w + 1);
   endfunction

endpackage

// File: rtl/bp_fe_bp_inflight_fifo.sv
// Flushable circular buffer holding in-flight predictions in fetch order.
// Pointers wrap modulo els_p (power of two); a count register separates
// full from empty. Flush beats any simultaneous push or pop.
module bp_fe_bp_inflight_fifo #(
   parameter int width_p = 10,
   parameter int els_p   = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic [width_p-1:0]         data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [width_p-1:0]         head_o,
   output logic [$clog2(els_p):0]     count_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(els_p);
   localparam int CNT_W = PTR_W + 1;

   logic [width_p-1:0] mem_q [els_p];
   logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full, push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CNT_W'(els_p));
   assign pop_ok  = pop_i & ~empty_o & ~flush_i;
   assign push_ok = push_i & ~flush_i & (~full | pop_ok);
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next state; flush drops every entry.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/bp_fe_bht_idx_gen.sv
// BHT index generator: hashes fetch PC (with speculative GHR under gshare)
// into the predictor read index, forwards the prediction to fetch, tracks
// in-flight predictions and drives predictor updates / GHR repair on
// resolution. Define BP_FE_IDX_GEN_GSHARE_EN for gshare; otherwise bimodal.
// ghist_width_p must be >= 2 and <= bht_idx_width_p.
module bp_fe_bht_idx_gen
   import bp_fe_bp_pkg::*;
#(
   parameter int vaddr_width_p   = 39,
   parameter int bht_idx_width_p = 9,
   parameter int ghist_width_p   = 9,
   parameter int pc_lsb_p        = 2,
   parameter int fifo_els_p      = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       fetch_v_i,
   input  logic [vaddr_width_p-1:0]   fetch_pc_i,
   output logic                       fetch_ready_o,
   output logic                       pred_v_o,
   output logic                       pred_taken_o,
   output logic                       r_v_o,
   output logic [bht_idx_width_p-1:0] idx_r_o,
   input  logic                       predict_i,
   input  logic                       res_v_i,
   input  logic                       res_taken_i,
   output logic                       w_v_o,
   output logic [bht_idx_width_p-1:0] idx_w_o,
   output logic                       correct_o,
   output logic                       mispredict_o
);

   localparam int CNT_W   = $clog2(fifo_els_p) + 1;
   localparam int ENTRY_W = bp_entry_width(bht_idx_width_p, ghist_width_p);

`ifdef BP_FE_IDX_GEN_GSHARE_EN
   typedef struct packed {
      logic [bht_idx_width_p-1:0] idx;
      logic                       pred;
      logic [ghist_width_p-1:0]   ghist;
   } entry_s;
`else
   typedef struct packed {
      logic [bht_idx_width_p-1:0] idx;
      logic                       pred;
   } entry_s;
`endif

   logic                       s1_v_q, s1_v_d;
   logic [bht_idx_width_p-1:0] s1_idx_q, s1_idx_d;
   logic                       w_v_q, w_v_d, correct_q, correct_d;
   logic                       mispredict_q, mispredict_d;
   logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
   logic [bht_idx_width_p-1:0] hash_idx;
   logic [CNT_W-1:0]           count, occupancy;
   logic                       empty, accept, pop, push, wrong, flush;
   entry_s                     head, push_entry;
   logic [ENTRY_W-1:0]         head_raw;
   logic                       unused_pc_bits;

   // Only the index window of the PC feeds the hash.
   assign unused_pc_bits = ^fetch_pc_i;

   // Resolution always targets the oldest entry; a wrong head flushes.
   assign pop   = res_v_i & ~empty;
   assign head  = entry_s'(head_raw);
   assign wrong = head.pred ^ res_taken_i;
   assign flush = pop & wrong;

   // Reserve a slot for the stage-1 entry so its push can never overflow.
   assign occupancy     = count + CNT_W'(s1_v_q);
   assign fetch_ready_o = ~reset_i & ~flush & (occupancy < CNT_W'(fifo_els_p));
   assign accept        = fetch_v_i & fetch_ready_o;
   assign r_v_o         = accept;
   assign idx_r_o       = hash_idx;

   // A stage-1 entry caught by a flush is squashed: no prediction, no push.
   assign push         = s1_v_q & ~flush;
   assign pred_v_o     = push;
   assign pred_taken_o = predict_i;

   assign w_v_o        = w_v_q;
   assign idx_w_o      = idx_w_q;
   assign correct_o    = correct_q;
   assign mispredict_o = mispredict_q;

`ifdef BP_FE_IDX_GEN_GSHARE_EN
   logic [ghist_width_p-1:0] ghr_q, ghr_d, ghe;
   logic [ghist_width_p-1:0] s1_ghe_q, s1_ghe_d;

   // Bypass the pending stage-1 history shift so back-to-back fetches hash
   // against the newest speculative history.
   assign ghe      = s1_v_q ? {ghr_q[ghist_width_p-2:0], predict_i} : ghr_q;
   assign hash_idx = fetch_pc_i[pc_lsb_p +: bht_idx_width_p] ^ bht_idx_width_p'(ghe);

   assign push_entry.idx   = s1_idx_q;
   assign push_entry.pred  = predict_i;
   assign push_entry.ghist = s1_ghe_q;

   // GHR next state: repair from the head snapshot beats speculative shift.
   always_comb begin
      ghr_d    = ghr_q;
      s1_ghe_d = accept ? ghe : s1_ghe_q;
      if (flush)
         ghr_d = {head.ghist[ghist_width_p-2:0], res_taken_i};
      else if (s1_v_q)
         ghr_d = {s1_ghe_q[ghist_width_p-2:0], predict_i};
   end

   // History registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ghr_q    <= '0;
         s1_ghe_q <= '0;
      end else begin
         ghr_q    <= ghr_d;
         s1_ghe_q <= s1_ghe_d;
      end
   end
`else
   assign hash_idx = fetch_pc_i[pc_lsb_p +: bht_idx_width_p];

   assign push_entry.idx  = s1_idx_q;
   assign push_entry.pred = predict_i;
`endif

   // Stage-1 capture and registered predictor update / mispredict pulse.
   always_comb begin
      s1_v_d       = accept;
      s1_idx_d     = accept ? hash_idx : s1_idx_q;
      w_v_d        = pop;
      idx_w_d      = pop ? head.idx : idx_w_q;
      correct_d    = pop & ~wrong;
      mispredict_d = flush;
   end

   // Pipeline registers; reset drops everything in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_v_q       <= 1'b0;
         s1_idx_q     <= '0;
         w_v_q        <= 1'b0;
         idx_w_q      <= '0;
         correct_q    <= 1'b0;
         mispredict_q <= 1'b0;
      end else begin
         s1_v_q       <= s1_v_d;
         s1_idx_q     <= s1_idx_d;
         w_v_q        <= w_v_d;
         idx_w_q      <= idx_w_d;
         correct_q    <= correct_d;
         mispredict_q <= mispredict_d;
      end
   end

   bp_fe_bp_inflight_fifo #(
      .width_p (ENTRY_W),
      .els_p   (fifo_els_p)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .flush_i (flush),
      .head_o  (head_raw),
      .count_o (count),
      .empty_o (empty)
   );

`ifndef SYNTHESIS
   // Resolving with nothing in flight is a backend protocol error; ignored here.
   always_ff @(posedge clk_i) begin
      if (!reset_i)
         assert (!(res_v_i && empty))
         else $warning("res_v_i asserted with no prediction in flight; ignored");
   end
`endif

endmodule

// File: tb/tb_bp_fe_bht_idx_gen.sv
// Directed bench for bp_fe_bht_idx_gen; expectations follow the build
// selected by BP_FE_IDX_GEN_GSHARE_EN (bimodal when undefined).
module tb_bp_fe_bht_idx_gen;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        fetch_v_i;
   logic [38:0] fetch_pc_i;
   logic        fetch_ready_o, pred_v_o, pred_taken_o, r_v_o;
   logic [8:0]  idx_r_o, idx_w_o;
   logic        predict_i, res_v_i, res_taken_i;
   logic        w_v_o, correct_o, mispredict_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bp_fe_bht_idx_gen dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .fetch_v_i     (fetch_v_i),
      .fetch_pc_i    (fetch_pc_i),
      .fetch_ready_o (fetch_ready_o),
      .pred_v_o      (pred_v_o),
      .pred_taken_o  (pred_taken_o),
      .r_v_o         (r_v_o),
      .idx_r_o       (idx_r_o),
      .predict_i     (predict_i),
      .res_v_i       (res_v_i),
      .res_taken_i   (res_taken_i),
      .w_v_o         (w_v_o),
      .idx_w_o       (idx_w_o),
      .correct_o     (correct_o),
      .mispredict_o  (mispredict_o)
   );

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      reset_i = 1'b1; fetch_v_i = 1'b0; fetch_pc_i = '0; predict_i = 1'b0;
      res_v_i = 1'b0; res_taken_i = 1'b0;
      tick; tick;
      reset_i = 1'b0;
   endtask

   task automatic test_reset;
      reset_i = 1'b1; fetch_v_i = 1'b1; fetch_pc_i = 39'h1000; predict_i = 1'b0;
      res_v_i = 1'b0; res_taken_i = 1'b0;
      tick; tick; #2;
      checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got %0b exp 0", fetch_ready_o); end
      fetch_v_i = 1'b0;
      tick; reset_i = 1'b0; #2;
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0b exp 1", fetch_ready_o); end
      checks++; if ({pred_v_o, w_v_o, mispredict_o, correct_o} !== 4'b0000) begin errors++; $display("FAIL rst_outs got %4b exp 0000", {pred_v_o, w_v_o, mispredict_o, correct_o}); end
      checks++; if (idx_w_o !== 9'h000) begin errors++; $display("FAIL rst_idx_w got %0h exp 0", idx_w_o); end
   endtask

   task automatic test_read;
      logic [8:0] exp_idx;
      do_reset;
      fetch_v_i = 1'b1; fetch_pc_i = 39'h1000; #2;
      checks++; if (r_v_o !== 1'b1) begin errors++; $display("FAIL read_r_v got %0b exp 1", r_v_o); end
      checks++; if (idx_r_o !== 9'h000) begin errors++; $display("FAIL read_idx got %0h exp 0", idx_r_o); end
      tick; fetch_v_i = 1'b0; predict_i = 1'b1; #2;
      checks++; if ({pred_v_o, pred_taken_o, r_v_o} !== 3'b110) begin errors++; $display("FAIL read_pred got %3b exp 110", {pred_v_o, pred_taken_o, r_v_o}); end
      tick; predict_i = 1'b0; fetch_v_i = 1'b1; fetch_pc_i = 39'h1008; #2;
`ifdef BP_FE_IDX_GEN_GSHARE_EN
      exp_idx = 9'h003;
`else
      exp_idx = 9'h002;
`endif
      checks++; if (idx_r_o !== exp_idx) begin errors++; $display("FAIL read_idx2 got %0h exp %0h", idx_r_o, exp_idx); end
      tick; fetch_v_i = 1'b0; #2;
      checks++; if ({pred_v_o, pred_taken_o} !== 2'b10) begin errors++; $display("FAIL read_pred2 got %2b exp 10", {pred_v_o, pred_taken_o}); end
   endtask

   task automatic test_back_to_back;
      do_reset;
      fetch_v_i = 1'b1; fetch_pc_i = 39'h1000; #2;
      checks++; if (idx_r_o !== 9'h000) begin errors++; $display("FAIL b2b_idx0 got %0h exp 0", idx_r_o); end
      tick; fetch_pc_i = 39'h1004; predict_i = 1'b1; #2;
      checks++; if ({r_v_o, pred_v_o, pred_taken_o} !== 3'b111) begin errors++; $display("FAIL b2b_flags got %3b exp 111", {r_v_o, pred_v_o, pred_taken_o}); end
`ifdef BP_FE_IDX_GEN_GSHARE_EN
      checks++; if (idx_r_o !== 9'h000) begin errors++; $display("FAIL b2b_idx1 got %0h exp 0", idx_r_o); end
`else
      checks++; if (idx_r_o !== 9'h001) begin errors++; $display("FAIL b2b_idx1 got %0h exp 1", idx_r_o); end
`endif
      tick; fetch_v_i = 1'b0; predict_i = 1'b0; #2;
      checks++; if ({pred_v_o, pred_taken_o} !== 2'b10) begin errors++; $display("FAIL b2b_pred2 got %2b exp 10", {pred_v_o, pred_taken_o}); end
      tick; #2;
      checks++; if (pred_v_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b exp 0", pred_v_o); end
   endtask

   task automatic test_full;
      do_reset;
      for (int k = 0; k < 8; k++) begin
         fetch_v_i = 1'b1; fetch_pc_i = 39'h1000 + 39'(4 * k); predict_i = (k > 0); #2;
         checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready%0d got %0b exp 1", k, fetch_ready_o); end
         tick;
      end
      fetch_pc_i = 39'h1020; predict_i = 1'b1; #2;
      checks++; if ({fetch_ready_o, r_v_o} !== 2'b00) begin errors++; $display("FAIL full_stall got %2b exp 00", {fetch_ready_o, r_v_o}); end
      tick; predict_i = 1'b0; res_v_i = 1'b1; res_taken_i = 1'b1; #2;
      checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL full_stall2 got %0b exp 0", fetch_ready_o); end
      tick; res_v_i = 1'b0; fetch_v_i = 1'b0; #2;
      checks++; if ({w_v_o, correct_o, mispredict_o} !== 3'b110) begin errors++; $display("FAIL full_upd got %3b exp 110", {w_v_o, correct_o, mispredict_o}); end
      checks++; if (idx_w_o !== 9'h000) begin errors++; $display("FAIL full_idx_w got %0h exp 0", idx_w_o); end
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_back got %0b exp 1", fetch_ready_o); end
      for (int j = 1; j < 8; j++) begin
         res_v_i = 1'b1; res_taken_i = 1'b1;
         tick;
         checks++; if ({w_v_o, correct_o} !== 2'b11) begin errors++; $display("FAIL drain_upd%0d got %2b exp 11", j, {w_v_o, correct_o}); end
`ifndef BP_FE_IDX_GEN_GSHARE_EN
         checks++; if (idx_w_o !== 9'(j)) begin errors++; $display("FAIL drain_idx%0d got %0h exp %0h", j, idx_w_o, j); end
`endif
      end
      res_v_i = 1'b0;
      tick; #2;
      checks++; if (w_v_o !== 1'b0) begin errors++; $display("FAIL drain_done got %0b exp 0", w_v_o); end
   endtask

   task automatic test_mispredict;
      logic [6:0] pv;
      logic [8:0] exp_w, exp_r;
      pv = 7'b0011010;  // bit c = predict_i driven in cycle c
      do_reset;
      for (int c = 0; c < 7; c++) begin
         fetch_v_i = (c < 6); fetch_pc_i = 39'h1000 + 39'(4 * c); predict_i = pv[c]; #2;
`ifdef BP_FE_IDX_GEN_GSHARE_EN
         if (c == 3) begin
            checks++; if (idx_r_o !== 9'h006) begin errors++; $display("FAIL mp_hash_h0 got %0h exp 6", idx_r_o); end
         end
`endif
         tick;
      end
      fetch_v_i = 1'b0;
      res_v_i = 1'b1; res_taken_i = 1'b1; tick;           // f0 pred 1
      res_taken_i = 1'b0; #2;                              // f1 pred 0
      checks++; if ({w_v_o, correct_o} !== 2'b11) begin errors++; $display("FAIL mp_f0 got %2b exp 11", {w_v_o, correct_o}); end
      tick;
      res_taken_i = 1'b1; fetch_v_i = 1'b1; fetch_pc_i = 39'h1000; #2;  // f2 pred 1
      checks++; if (r_v_o !== 1'b1) begin errors++; $display("FAIL mp_accept got %0b exp 1", r_v_o); end
      tick;
      res_taken_i = 1'b0; fetch_pc_i = 39'h1004; predict_i = 1'b1; #2;  // h0 pred 1 -> wrong
      checks++; if ({fetch_ready_o, r_v_o, pred_v_o} !== 3'b000) begin errors++; $display("FAIL mp_squash got %3b exp 000", {fetch_ready_o, r_v_o, pred_v_o}); end
      checks++; if ({w_v_o, correct_o, mispredict_o} !== 3'b110) begin errors++; $display("FAIL mp_f2 got %3b exp 110", {w_v_o, correct_o, mispredict_o}); end
      tick;
      res_v_i = 1'b1; res_taken_i = 1'b0; fetch_pc_i = 39'h1000; predict_i = 1'b0; #2;
`ifdef BP_FE_IDX_GEN_GSHARE_EN
      exp_w = 9'h006; exp_r = 9'h00A;
`else
      exp_w = 9'h003; exp_r = 9'h000;
`endif
      checks++; if ({w_v_o, correct_o, mispredict_o} !== 3'b101) begin errors++; $display("FAIL mp_upd got %3b exp 101", {w_v_o, correct_o, mispredict_o}); end
      checks++; if (idx_w_o !== exp_w) begin errors++; $display("FAIL mp_idx_w got %0h exp %0h", idx_w_o, exp_w); end
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL mp_ready got %0b exp 1", fetch_ready_o); end
      checks++; if (idx_r_o !== exp_r) begin errors++; $display("FAIL mp_repair_idx got %0h exp %0h", idx_r_o, exp_r); end
      tick;
      res_v_i = 1'b0; fetch_v_i = 1'b0; #2;
      checks++; if ({w_v_o, mispredict_o, pred_v_o} !== 3'b001) begin errors++; $display("FAIL mp_empty_res got %3b exp 001", {w_v_o, mispredict_o, pred_v_o}); end
   endtask

   task automatic test_reset_mid;
      do_reset;
      for (int c = 0; c < 4; c++) begin
         fetch_v_i = (c < 3); fetch_pc_i = 39'h2000 + 39'(4 * c); predict_i = 1'b1;
         tick;
      end
      fetch_v_i = 1'b0; reset_i = 1'b1;
      tick;
      reset_i = 1'b0; res_v_i = 1'b1; res_taken_i = 1'b1;
      tick;
      res_v_i = 1'b0; #2;
      checks++; if ({w_v_o, pred_v_o, fetch_ready_o} !== 3'b001) begin errors++; $display("FAIL midrst got %3b exp 001", {w_v_o, pred_v_o, fetch_ready_o}); end
   endtask

   initial begin
      test_reset;
      test_read;
      test_back_to_back;
      test_full;
      test_mispredict;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
